// File: rtl/led_matrix_scanner.sv
`default_nettype none
// led_matrix_scanner: double-buffered frame sink that time-multiplexes a ROWS x COLS
// frame onto one-hot row drives, with a dark blanking gap before every row.
module led_matrix_scanner #(
  parameter int ROWS         = 6,
  parameter int COLS         = 6,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   restart,
  input  logic                   enable,
  input  logic [ROWS*COLS-1:0]   leds,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        col_data,
  output logic                   frame_done,
  output logic                   scanning
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ROW_W-1:0]     row;
  logic [ROW_W-1:0]     row_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 frame_start;

  logic [ROWS*COLS-1:0] active;
  logic [ROWS*COLS-1:0] pending;
  logic                 pending_full;
  logic                 accept;

  logic [ROWS-1:0]      row_sel_d;
  logic [COLS-1:0]      col_data_d;
  logic                 frame_done_d;
  logic                 scanning_d;

  assign accept      = frame_valid && !pending_full;
  assign frame_ready = !pending_full;

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state <= IDLE;
      row   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    row_next    = row;
    cnt_next    = cnt;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next  = BLANK;
          row_next    = '0;
          cnt_next    = '0;
          frame_start = 1'b1;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = SHOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_next = '0;
          if (row == ROW_LAST) begin
            // enable only matters here: a frame always runs to completion
            row_next = '0;
            if (enable) begin
              state_next  = BLANK;
              frame_start = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            row_next   = row + ROW_W'(1);
            state_next = BLANK;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        row_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Swap uses the pre-edge pending flag, so a same-cycle accept survives in pending.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      if (frame_start && pending_full) begin
        active <= pending;
      end
      if (accept) begin
        pending <= leds;
      end
      pending_full <= (pending_full && !frame_start) || accept;
    end
  end

  always_comb begin
    row_sel_d    = '0;
    col_data_d   = '0;
    frame_done_d = (state == SHOW) && (cnt == DWELL_LAST) && (row == ROW_LAST);
    scanning_d   = (state != IDLE);
    if (state == SHOW) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row == ROW_W'(r)) begin
          row_sel_d[r] = 1'b1;
          col_data_d   = active[r*COLS +: COLS];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
      scanning   <= 1'b0;
    end else begin
      row_sel    <= row_sel_d;
      col_data   <= col_data_d;
      frame_done <= frame_done_d;
      scanning   <= scanning_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// Bench for led_matrix_scanner: scenario tasks with random frames, checked against a
// frame-position reference model built from row/frame period arithmetic.
module tb_led_matrix_scanner;

  localparam int R  = 6;
  localparam int C  = 6;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int RP = DW + BL;
  localparam int FP = R * RP;

  logic          clk = 1'b0;
  logic          restart;
  logic          enable;
  logic [35:0]   leds;
  logic          frame_valid;
  logic          frame_ready;
  logic [5:0]    row_sel;
  logic [5:0]    col_data;
  logic          frame_done;
  logic          scanning;

  int checks = 0;
  int errors = 0;

  // Model: m_s = position of the scan within the frame (-1 idle), m_t = position
  // currently visible on the pins (one clock behind), m_out = frame on the pins.
  int          m_s;
  int          m_t;
  logic [35:0] m_active;
  logic [35:0] m_pending;
  logic [35:0] m_out;
  bit          m_pf;

  led_matrix_scanner #(
    .ROWS(R), .COLS(C), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
  ) dut (
    .clock(clk), .restart(restart), .enable(enable), .leds(leds),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .row_sel(row_sel),
    .col_data(col_data), .frame_done(frame_done), .scanning(scanning)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s = -1; m_t = -1; m_pf = 0;
    m_active = '0; m_pending = '0; m_out = '0;
  endtask

  task automatic tick();
    int  ns;
    bit  acc;
    @(posedge clk);
    acc   = frame_valid && !m_pf;
    m_t   = m_s;
    m_out = m_active;
    if (m_s == -1 || m_s == FP - 1) ns = enable ? 0 : -1;
    else                            ns = m_s + 1;
    if (ns == 0 && m_pf) begin
      m_active = m_pending;
      m_pf     = 0;
    end
    if (acc) begin
      m_pending = leds;
      m_pf      = 1;
    end
    m_s = ns;
    #1;
  endtask

  function automatic logic [14:0] exp_vec();
    logic [5:0] rs, cd;
    logic       dn, sc;
    int         rw;
    rs = '0; cd = '0; dn = 1'b0; sc = 1'b0;
    if (m_t >= 0) begin
      sc = 1'b1;
      rw = m_t / RP;
      if ((m_t % RP) >= BL) begin
        rs = 6'(1 << rw);
        cd = m_out[rw*C +: C];
      end
      dn = (m_t == FP - 1);
    end
    return {rs, cd, dn, sc, !m_pf};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {row_sel, col_data, frame_done, scanning, frame_ready};
  endfunction

  function automatic logic [35:0] rnd36();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[35:0];
  endfunction

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * FP && !ok; i++) begin
      tick();
      if (m_s == 0) ok = 1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec()); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    frame_valid = 1; leds = rnd36(); enable = 1;
    tick();
    frame_valid = 0;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_prescan got=%h exp=%h", dut_vec(), exp_vec()); end
      if (m_t >= 0 && (m_t % RP) >= BL) ok = 1;
    end
    checks++;
    if (row_sel === 6'd0 || frame_ready !== 1'b0) begin
      errors++; $display("FAIL reset_midshow_setup row_sel=%h ready=%b required lit row and ready=0", row_sel, frame_ready);
    end
    restart = 1;
    #2;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_async got=%h exp=%h", dut_vec(), exp_vec()); end
    enable = 0;
    #1 restart = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_dark got=%h exp=%h", dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_single_row();
    int lit, dn;
    frame_valid = 1; leds = 36'h0_0000_003F;
    tick();
    frame_valid = 0;
    enable = 1;
    tick();
    lit = 0; dn = 0;
    for (int i = 0; i < FP; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL single_row t=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
      if (col_data === 6'h3F) lit++;
      if (frame_done === 1'b1) dn++;
    end
    checks++;
    if (lit != DW || dn != 1) begin errors++; $display("FAIL single_row_counts lit=%0d done=%0d required %0d and 1", lit, dn, DW); end
  endtask

  task automatic test_double_buffer();
    logic [35:0] a, b, x;
    bit ok;
    a = rnd36(); b = rnd36(); x = rnd36();
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL db_start1 timeout got=0 required=1"); end
    frame_valid = 1; leds = a;
    tick();
    frame_valid = 0;
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL db_start2 timeout got=0 required=1"); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL db_frame_a got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    frame_valid = 1; leds = b;
    tick();
    frame_valid = 0;
    checks++;
    if (frame_ready !== 1'b0) begin errors++; $display("FAIL db_ready_low got=%b required=0", frame_ready); end
    frame_valid = 1; leds = x;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL db_third_ignored got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    frame_valid = 0;
    wait_start(ok);
    checks++;
    if (!ok || frame_ready !== 1'b1) begin errors++; $display("FAIL db_ready_after_swap got=%b required=1", frame_ready); end
    for (int i = 0; i < FP; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL db_frame_b t=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_wrap_accept();
    logic [35:0] c, d, e;
    bit ok;
    c = rnd36(); d = rnd36(); e = rnd36();
    wait_start(ok);
    frame_valid = 1; leds = c;
    tick();
    frame_valid = 0;
    ok = 0;
    for (int i = 0; i < FP && !ok; i++) begin
      tick();
      if (m_s == FP - 2) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_align timeout got=0 required=1"); end
    frame_valid = 1; leds = d;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL wrap_hold got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    frame_valid = 0;
    checks++;
    if (frame_ready !== 1'b0) begin errors++; $display("FAIL wrap_pending_full got=%b required=0", frame_ready); end
    for (int i = 0; i < FP; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL wrap_shows_c t=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    wait_start(ok);
    ok = 0;
    for (int i = 0; i < FP && !ok; i++) begin
      tick();
      if (m_s == FP - 1) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_align2 timeout got=0 required=1"); end
    frame_valid = 1; leds = e;
    tick();
    frame_valid = 0;
    checks++;
    if (frame_ready !== 1'b0) begin errors++; $display("FAIL wrap_coincident_ready got=%b required=0", frame_ready); end
    for (int i = 0; i < FP; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL wrap_held_active t=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int dn, lit, n;
    ok = 0;
    for (int i = 0; i < 2 * FP && !ok; i++) begin
      tick();
      if (m_s >= 0 && m_s / RP == 2) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL drop_align timeout got=0 required=1"); end
    enable = 0;
    dn = 0; lit = 0; ok = 0;
    for (int i = 0; i < 2 * FP && !ok; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL drop_finish got=%h exp=%h", dut_vec(), exp_vec()); end
      if (frame_done === 1'b1) dn++;
      if (row_sel[5:3] !== 3'b000) lit++;
      if (m_t < 0) ok = 1;
    end
    checks++;
    if (!ok || dn != 1 || lit != 3 * DW) begin
      errors++; $display("FAIL drop_counts done=%0d lit=%0d required 1 and %0d", dn, lit, 3 * DW);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL drop_idle got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    enable = 1;
    tick();
    n = 0; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL drop_restart got=%h exp=%h", dut_vec(), exp_vec()); end
      n++;
      if (row_sel !== 6'd0) ok = 1;
    end
    checks++;
    if (!ok || n != BL + 1) begin errors++; $display("FAIL drop_first_lit latency got=%0d required=%0d", n, BL + 1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      frame_valid = ($urandom_range(0, 3) == 0);
      leds = rnd36();
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    frame_valid = 0;
  endtask

  task automatic test_walking();
    bit ok;
    int lit;
    logic [35:0] pat;
    enable = 1; frame_valid = 0;
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL walk_sync timeout got=0 required=1"); end
    for (int k = 0; k < R * C; k++) begin
      pat = 36'd1 << k;
      frame_valid = 1; leds = pat;
      tick();
      frame_valid = 0;
      wait_start(ok);
      checks++; if (!ok) begin errors++; $display("FAIL walk_start k=%0d timeout", k); end
      lit = 0;
      for (int i = 0; i < FP; i++) begin
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL walk k=%0d t=%0d got=%h exp=%h", k, i, dut_vec(), exp_vec()); end
        checks++;
        if ($countones(row_sel) > 1) begin errors++; $display("FAIL walk_onehot row_sel=%b required at most one bit", row_sel); end
        if (col_data !== 6'd0) begin
          lit++;
          checks++;
          if (row_sel !== 6'(1 << (k / C)) || col_data !== 6'(1 << (k % C))) begin
            errors++; $display("FAIL walk_pos k=%0d row_sel=%b col=%b required row %0d col %0d", k, row_sel, col_data, k / C, k % C);
          end
        end
      end
      checks++;
      if (lit != DW) begin errors++; $display("FAIL walk_lit k=%0d got=%0d required=%0d", k, lit, DW); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    restart = 1; enable = 0; frame_valid = 0; leds = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 restart = 0;
    test_reset();
    test_single_row();
    test_double_buffer();
    test_wrap_accept();
    test_enable_drop();
    test_random();
    test_walking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
